// File: rtl/alu_issue_seq.sv
// Issue sequencer for the combinational data ALU: registers operands, waits the per-opcode
// settle time, captures the result into an in-order response FIFO. Optional stats: ALU_SEQ_STATS_EN.
module alu_issue_seq #(
  parameter int TAG_W      = 4,
  parameter int RESP_DEPTH = 2,
  parameter int MC_WAIT    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [16:0]       req_op1,
  input  logic [16:0]       req_op2,
  input  logic [3:0]        req_ctrl,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [16:0]       alu_op1,
  output logic [16:0]       alu_op2,
  output logic [3:0]        alu_ctrl,
  input  logic [32:0]       alu_data,
  input  logic              alu_sign,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [32:0]       resp_data,
  output logic              resp_sign,
  output logic              resp_err,
  output logic [TAG_W-1:0]  resp_tag
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]       stat_ops,
  output logic [15:0]       stat_err
`endif
);

  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int WW = $clog2(MC_WAIT + 1);

  typedef struct packed {
    logic [32:0]      data;
    logic             sign;
    logic             err;
    logic [TAG_W-1:0] tag;
  } resp_t;

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

  state_t           state, state_nxt;
  logic [WW-1:0]    cnt;
  logic [TAG_W-1:0] tag_q;
  logic [32:0]      last_result;

  resp_t            mem [RESP_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

  logic             accept, issue, push, pop;
  resp_t            push_ent, head;

  assign req_ready = rst_n && (state == IDLE) && (count < CW'(RESP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign pop       = resp_ready && (count != '0);
  assign resp_valid = (count != '0);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    push      = 1'b0;
    push_ent  = '0;
    case (state)
      IDLE: if (accept) begin
        // Divide-by-zero and NOP are answered here so the ALU never sees them.
        if (req_ctrl == 4'b0010 && req_op2 == '0) begin
          push         = 1'b1;
          push_ent.err = 1'b1;
          push_ent.tag = req_tag;
        end else if (req_ctrl == 4'b1001) begin
          push          = 1'b1;
          push_ent.data = last_result;
          push_ent.tag  = req_tag;
        end else begin
          issue     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: if (cnt <= WW'(1)) state_nxt = CAPTURE;
      CAPTURE: begin
        push          = 1'b1;
        push_ent.data = alu_data;
        // signFlag is only meaningful for add/sub.
        push_ent.sign = (alu_ctrl == 4'b0000 || alu_ctrl == 4'b0001) ? alu_sign : 1'b0;
        push_ent.tag  = tag_q;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      tag_q       <= '0;
      last_result <= '0;
      alu_op1     <= '0;
      alu_op2     <= '0;
      alu_ctrl    <= '0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        alu_op1  <= req_op1;
        alu_op2  <= req_op2;
        alu_ctrl <= req_ctrl;
        tag_q    <= req_tag;
        cnt      <= (req_ctrl == 4'b0010 || req_ctrl == 4'b0011) ? WW'(MC_WAIT) : WW'(1);
      end else if (state == WAIT) begin
        cnt <= cnt - 1'b1;
      end
      if (state == CAPTURE) last_result <= alu_data;
    end
  end

  // Response FIFO; at most one op in flight, so req_ready gating keeps pushes from overflowing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_ent;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    head      = mem[rd_ptr];
    resp_data = resp_valid ? head.data : '0;
    resp_sign = resp_valid ? head.sign : 1'b0;
    resp_err  = resp_valid ? head.err  : 1'b0;
    resp_tag  = resp_valid ? head.tag  : '0;
  end

`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ops <= '0;
      stat_err <= '0;
    end else if (push) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 1'b1;
      if (push_ent.err && stat_err != 16'hFFFF) stat_err <= stat_err + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq with a behavioural ALU stub on the alu_* side.
module tb_alu_issue_seq;
  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, alu_sign, resp_valid, resp_ready;
  logic        resp_sign, resp_err;
  logic [16:0] req_op1, req_op2, alu_op1, alu_op2;
  logic [3:0]  req_ctrl, req_tag, alu_ctrl, resp_tag;
  logic [32:0] alu_data, resp_data;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_ops, stat_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [16:0] e_op1, e_op2;
  logic [3:0]  e_ctrl;

  alu_issue_seq #(.TAG_W(4), .RESP_DEPTH(2), .MC_WAIT(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_ctrl(req_ctrl), .req_tag(req_tag),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
    .alu_data(alu_data), .alu_sign(alu_sign),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_sign(resp_sign), .resp_err(resp_err), .resp_tag(resp_tag)
`ifdef ALU_SEQ_STATS_EN
    , .stat_ops(stat_ops), .stat_err(stat_err)
`endif
  );

  always #5 clk = ~clk;

  // Combinational ALU stub
  logic signed [32:0] a_s, b_s;
  always_comb begin
    a_s = 33'(signed'(alu_op1));
    b_s = 33'(signed'(alu_op2));
    case (alu_ctrl)
      4'b0000, 4'b1000: alu_data = a_s + b_s;
      4'b0001:          alu_data = a_s - b_s;
      4'b0010:          alu_data = (b_s != 0) ? a_s / b_s : '0;
      4'b0011:          alu_data = a_s * b_s;
      4'b0100:          alu_data = b_s;
      4'b0101:          alu_data = a_s;
      default:          alu_data = '0;
    endcase
    alu_sign = alu_data[32];
  end

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return one cycle after it is accepted.
  task automatic send(input logic [16:0] o1, input logic [16:0] o2,
                      input logic [3:0] c, input logic [3:0] t);
    int k;
    req_op1 = o1; req_op2 = o2; req_ctrl = c; req_tag = t; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin step(); k++; end
    if (k >= 20) chk("send_timeout", 64'(k), 64'(0));
    step();
    req_valid = 1'b0;
  endtask

  // Count cycles until resp_valid (accept cycle is 0) while checking alu_* stay put.
  task automatic wait_resp(input int exp_lat, input string nm);
    int k;
    bit bad;
    k = 1; bad = 1'b0;
    while (!resp_valid && k < 20) begin
      if (alu_op1 !== e_op1 || alu_op2 !== e_op2 || alu_ctrl !== e_ctrl) bad = 1'b1;
      step();
      k++;
    end
    chk({nm, "_lat"}, 64'(k), 64'(exp_lat));
    chk({nm, "_alu_stable"}, 64'(bad), 64'(0));
  endtask

  task automatic chk_resp(input string nm, input logic [32:0] d, input logic s,
                          input logic e, input logic [3:0] t);
    chk({nm, "_data"}, 64'(resp_data), 64'(d));
    chk({nm, "_sign"}, 64'(resp_sign), 64'(s));
    chk({nm, "_err"},  64'(resp_err),  64'(e));
    chk({nm, "_tag"},  64'(resp_tag),  64'(t));
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    req_op1 = '0; req_op2 = '0; req_ctrl = '0; req_tag = '0;
    step(); step();
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_alu_op1", 64'(alu_op1), 64'(0));
    chk("rst_alu_ctrl", 64'(alu_ctrl), 64'(0));
    chk("rst_resp_data", 64'(resp_data), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'(1));

    // add 5+7
    e_op1 = 17'd5; e_op2 = 17'd7; e_ctrl = 4'b0000;
    send(17'd5, 17'd7, 4'b0000, 4'd1);
    wait_resp(3, "add");
    chk_resp("add", 33'h0_0000_000C, 1'b0, 1'b0, 4'd1);
    step();
    chk("add_popped", 64'(resp_valid), 64'(0));

    // sub 3-10
    e_op1 = 17'd3; e_op2 = 17'd10; e_ctrl = 4'b0001;
    send(17'd3, 17'd10, 4'b0001, 4'd2);
    wait_resp(3, "sub");
    chk_resp("sub", 33'h1_FFFF_FFF9, 1'b1, 1'b0, 4'd2);
    step();

    // mul -2*3
    e_op1 = 17'h1FFFE; e_op2 = 17'd3; e_ctrl = 4'b0011;
    send(17'h1FFFE, 17'd3, 4'b0011, 4'd3);
    wait_resp(5, "mul");
    chk_resp("mul", 33'h1_FFFF_FFFA, 1'b0, 1'b0, 4'd3);
    step();

    // div by zero: screened, ALU ports keep mul operands
    send(17'd100, 17'd0, 4'b0010, 4'd4);
    wait_resp(1, "div0");
    chk_resp("div0", 33'h0, 1'b0, 1'b1, 4'd4);
    chk("div0_alu_ctrl", 64'(alu_ctrl), 64'(4'b0011));
    step();

    // add 5+7 then NOP returns last result
    e_op1 = 17'd5; e_op2 = 17'd7; e_ctrl = 4'b0000;
    send(17'd5, 17'd7, 4'b0000, 4'd6);
    wait_resp(3, "add12");
    step();
    send(17'd1, 17'd1, 4'b1001, 4'd5);
    wait_resp(1, "nop");
    chk_resp("nop", 33'h0_0000_000C, 1'b0, 1'b0, 4'd5);
    step();

    // unknown opcode: single-cycle issue, stub ALU returns 0
    e_op1 = 17'd9; e_op2 = 17'd9; e_ctrl = 4'b1111;
    send(17'd9, 17'd9, 4'b1111, 4'd11);
    wait_resp(3, "unk");
    chk_resp("unk", 33'h0, 1'b0, 1'b0, 4'd11);
    step();

    // backpressure with two FIFO entries
    resp_ready = 1'b0;
    send(17'd1, 17'd1, 4'b0000, 4'd7);
    send(17'd2, 17'd2, 4'b0000, 4'd8);
    req_op1 = 17'd3; req_op2 = 17'd3; req_ctrl = 4'b0000; req_tag = 4'd9; req_valid = 1'b1;
    repeat (4) step();
    chk("bp_full_ready", 64'(req_ready), 64'(0));
    chk_resp("bp_head", 33'h2, 1'b0, 1'b0, 4'd7);
    step();
    chk("bp_hold_tag", 64'(resp_tag), 64'(7));
    chk("bp_hold_data", 64'(resp_data), 64'(2));
    resp_ready = 1'b1;
    step();
    chk("bp_ready_after_pop", 64'(req_ready), 64'(1));
    chk_resp("bp_second", 33'h4, 1'b0, 1'b0, 4'd8);
    step();
    req_valid = 1'b0;
    e_op1 = 17'd3; e_op2 = 17'd3; e_ctrl = 4'b0000;
    wait_resp(3, "bp_third");
    chk_resp("bp_third", 33'h6, 1'b0, 1'b0, 4'd9);
    step();

    // reset during the WAIT of a div
    send(17'd100, 17'd4, 4'b0010, 4'd10);
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(req_ready), 64'(0));
    step();
    rst_n = 1'b1;
    #1;
    chk("midrst_valid", 64'(resp_valid), 64'(0));
    chk("midrst_ready_after", 64'(req_ready), 64'(1));
    chk("midrst_alu_ctrl", 64'(alu_ctrl), 64'(0));
    repeat (6) step();
    chk("midrst_no_resp", 64'(resp_valid), 64'(0));

`ifdef ALU_SEQ_STATS_EN
    chk("stat_ops_clr", 64'(stat_ops), 64'(0));
    e_op1 = 17'd1; e_op2 = 17'd2; e_ctrl = 4'b0000;
    send(17'd1, 17'd2, 4'b0000, 4'd1);
    wait_resp(3, "st_add");
    step();
    send(17'd7, 17'd0, 4'b0010, 4'd2);
    wait_resp(1, "st_div0");
    step();
    send(17'd0, 17'd0, 4'b1001, 4'd3);
    wait_resp(1, "st_nop");
    step();
    chk("stat_ops3", 64'(stat_ops), 64'(3));
    chk("stat_err1", 64'(stat_err), 64'(1));
    req_op1 = '0; req_op2 = '0; req_ctrl = 4'b1001; req_tag = 4'd0; req_valid = 1'b1;
    repeat (70000) step();
    req_valid = 1'b0;
    step();
    chk("stat_ops_sat", 64'(stat_ops), 64'(16'hFFFF));
    chk("stat_err_hold", 64'(stat_err), 64'(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
